// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state encoding and reset ratio for the clock divider
package clkdiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  localparam int DEF_HALF = 2;
endpackage

// File: rtl/clkdiv_core.sv
// clkdiv_core: half-period counter, clk_out toggle and rise pulse
module clkdiv_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] half,
  input  logic             run,
  input  logic             clear,
  output logic             clk_out,
  output logic             rise,
  output logic             wrap
);
  logic [DIV_W-1:0] count;
  assign wrap = count == half - DIV_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count   <= '0;
      clk_out <= 1'b0;
      rise    <= 1'b0;
    end else if (clear || !run) begin
      count   <= '0;
      clk_out <= 1'b0;
      rise    <= 1'b0;
    end else begin
      count   <= wrap ? '0 : count + DIV_W'(1);
      clk_out <= clk_out ^ wrap;
      rise    <= wrap && !clk_out;
    end
endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run/stop FSM and half-period handshake around clkdiv_core
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int DIV_W        = 8,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             busy,
  output logic             clk_out,
  output logic             rise
);
  state_t state, state_n;
  logic [DIV_W-1:0] half_q, half_n, pend_half, pend_n;
  logic wrap, xfer, legal, run, fall, stop;
  assign cfg_ready = state != PEND;
  assign busy      = state == PEND;
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = xfer && |cfg_half;
  assign run       = state != IDLE;
  assign fall      = run && wrap && clk_out;
  // a stop request only takes effect in the low phase or when high ends
  assign stop      = !en && (!clk_out || fall);
  always_comb begin
    state_n = state;
    half_n  = half_q;
    pend_n  = pend_half;
    case (state)
      IDLE: begin
        state_n = en ? RUN : IDLE;
        half_n  = legal ? cfg_half : half_q;
      end
      RUN: begin
        state_n = legal ? PEND : stop ? IDLE : RUN;
        pend_n  = legal ? cfg_half : pend_half;
      end
      PEND: begin
        state_n = stop ? IDLE : fall ? RUN : PEND;
        half_n  = (stop || fall) ? pend_half : half_q;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      half_q    <= DIV_W'(DEFAULT_HALF);
      pend_half <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_n;
      half_q    <= half_n;
      pend_half <= pend_n;
      cfg_err   <= xfer && cfg_half == '0;
    end
  clkdiv_core #(.DIV_W(DIV_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .half    (half_q),
    .run     (run),
    .clear   (!en && !clk_out),
    .clk_out (clk_out),
    .rise    (rise),
    .wrap    (wrap)
  );
endmodule

// File: doc/clkdiv_ctrl.md
CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 SHALL have parameter: DIV_W, 8, width of the half-period configuration and counter.
REQ-002 SHALL have parameter: DEFAULT_HALF, 2, reset half-period in clk cycles (divide-by-4).
REQ-003 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: en  input  1  run request; 1 = generate clk_out, 0 = stop glitch-free.
REQ-006 SHALL have port: cfg_valid  input  1  new half-period offered.
REQ-007 SHALL have port: cfg_half  input  DIV_W  requested half-period in clk cycles; 0 is illegal.
REQ-008 SHALL have port: cfg_ready  output  1  controller can accept a configuration.
REQ-009 SHALL have port: cfg_err  output  1  one-cycle pulse: accepted cfg_half was 0 and was discarded.
REQ-010 SHALL have port: busy  output  1  a ratio change is pending.
REQ-011 SHALL have port: clk_out  output  1  registered divided clock, period 2*half_q clk cycles.
REQ-012 SHALL have port: rise  output  1  high only during the first clk cycle in which clk_out is 1.

Function
REQ-013 SHALL implement states IDLE, RUN and PEND.
REQ-014 SHALL hold clk_out=0 and counter=0 in IDLE; IDLE with en=1 SHALL go to RUN, and clk_out SHALL stay 0 for the first half_q cycles.
REQ-015 SHALL, in RUN/PEND, count counter 0..half_q-1; at half_q-1 it SHALL wrap to 0 and toggle clk_out.
REQ-016 SHALL drive cfg_ready = (state != PEND); a transfer occurs when cfg_valid and cfg_ready are both 1 on a clk edge.
REQ-017 SHALL, on transfer with cfg_half=0, pulse cfg_err for 1 cycle and change nothing else.
REQ-018 SHALL, on a legal transfer in IDLE, load half_q next cycle and stay in IDLE.
REQ-019 SHALL, on a legal transfer in RUN, store pend_half, enter PEND and drive busy=1; counting continues with the old half_q.
REQ-020 SHALL leave PEND at the wrap where clk_out falls 1->0: half_q<=pend_half, counter<=0, clk_out<=0, state RUN, busy<=0.
REQ-021 SHALL handle en=0 in RUN/PEND as follows: with clk_out=0, go to IDLE next cycle (low phase truncated); with clk_out=1, finish the high phase, then go to IDLE.
REQ-022 SHALL, when leaving PEND to IDLE, apply pend_half to half_q in the same cycle.
REQ-023 SHALL never produce a clk_out high phase shorter than half_q cycles of the ratio in force when that phase began.
REQ-024 SHALL support cfg_half=1 (divide-by-2) and cfg_half=2^DIV_W-1 with no counter overflow.
REQ-025 SHALL, when en toggles 0->1 in the same cycle as a legal transfer in IDLE, start RUN using the new half_q.

Reset
REQ-026 SHALL, on rst=1 at any time, immediately set: state IDLE, counter 0, clk_out 0, rise 0, cfg_err 0, busy 0, half_q=DEFAULT_HALF; any pending change is discarded.
REQ-027 SHALL drive cfg_ready=1 during and after reset.

Structure
REQ-028 SHALL place the state enum and the DEFAULT_HALF default in the shared package clkdiv_pkg.
REQ-029 SHALL implement counter/toggle/rise logic in sub-module clkdiv_core (inputs half, run, clear); clkdiv_ctrl SHALL hold only the FSM and handshake.

Verification
REQ-030 SHALL cover: reset, then en=1 with default -> clk_out period 4 clk cycles, 2 high/2 low, rise once per period.
REQ-031 SHALL cover: in RUN with half=2, cfg_half=5 while clk_out=1 -> busy=1, cfg_ready=0 until clk_out falls; then 10-cycle periods.
REQ-032 SHALL cover: cfg_half=0 transfer -> cfg_err pulses 1 cycle; ratio and state unchanged.
REQ-033 SHALL cover: half=3, en dropped in the first high-phase cycle -> high lasts 3 cycles, then clk_out=0 and state IDLE.
REQ-034 SHALL cover: rst asserted mid-PEND -> all outputs at reset values asynchronously; next run uses period 4, not the pending value.
REQ-035 SHALL cover: cfg_half=1 and cfg_half=255 -> periods 2 and 510 clk cycles exactly.
